// File: rtl/clock_group_reset_sequencer.sv
// Clock group reset sequencer: fans the input clock out to seven members and releases their
// resets one at a time after a hold period. Software re-sequence is enabled by RESET_SEQ_SW_REQ_EN.
module clock_group_reset_sequencer #(
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
`ifdef RESET_SEQ_SW_REQ_EN
  input  logic       sw_reset_req,
  output logic       sw_reset_ack,
`endif
  output logic       seq_done,
  output logic [1:0] seq_state,
  output logic       auto_out_member_allClocks_implicit_clock_clock,
  output logic       auto_out_member_allClocks_implicit_clock_reset,
  output logic       auto_out_member_allClocks_subsystem_sbus_0_clock,
  output logic       auto_out_member_allClocks_subsystem_sbus_0_reset,
  output logic       auto_out_member_allClocks_subsystem_sbus_1_clock,
  output logic       auto_out_member_allClocks_subsystem_sbus_1_reset,
  output logic       auto_out_member_allClocks_subsystem_mbus_clock,
  output logic       auto_out_member_allClocks_subsystem_mbus_reset,
  output logic       auto_out_member_allClocks_subsystem_fbus_clock,
  output logic       auto_out_member_allClocks_subsystem_fbus_reset,
  output logic       auto_out_member_allClocks_subsystem_cbus_clock,
  output logic       auto_out_member_allClocks_subsystem_cbus_reset,
  output logic       auto_out_member_allClocks_subsystem_pbus_clock,
  output logic       auto_out_member_allClocks_subsystem_pbus_reset
);

  localparam int MAX_CYCLES = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STAGGER_LAST = CW'(STAGGER_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } seqState_e;

  logic [1:0]    rstSync_r;
  seqState_e     state_r;
  logic [CW-1:0] cnt_r;
  logic [2:0]    idx_r;
  logic [6:0]    memberRst_r;
  logic          seqDone_r;
`ifdef RESET_SEQ_SW_REQ_EN
  logic          swAck_r;
  logic          swPending_r;
`endif

  // Two-flop reset synchronizer: asynchronous assertion, synchronous release
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rstSync_r <= 2'b00;
    end else begin
      rstSync_r <= {rstSync_r[0], 1'b1};
    end
  end

  // Sequencing FSM; the FSM stays parked until the synchronized release is seen
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_HOLD;
      cnt_r       <= '0;
      idx_r       <= 3'd0;
      memberRst_r <= 7'h7F;
      seqDone_r   <= 1'b0;
`ifdef RESET_SEQ_SW_REQ_EN
      swAck_r     <= 1'b0;
      swPending_r <= 1'b0;
`endif
    end else if (!rstSync_r[1]) begin
      state_r     <= ST_HOLD;
      cnt_r       <= '0;
      idx_r       <= 3'd0;
      memberRst_r <= 7'h7F;
      seqDone_r   <= 1'b0;
`ifdef RESET_SEQ_SW_REQ_EN
      swAck_r     <= 1'b0;
      swPending_r <= 1'b0;
`endif
    end else begin
`ifdef RESET_SEQ_SW_REQ_EN
      if (swAck_r && !sw_reset_req) begin
        swAck_r <= 1'b0;
      end
`endif
      case (state_r)
        ST_HOLD: begin
          if (cnt_r == HOLD_LAST) begin
            memberRst_r[0] <= 1'b0;
            cnt_r          <= '0;
            idx_r          <= 3'd1;
            state_r        <= ST_RELEASE;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (cnt_r == STAGGER_LAST) begin
            memberRst_r <= memberRst_r & ~(7'd1 << idx_r);
            cnt_r       <= '0;
            idx_r       <= idx_r + 3'd1;
            if (idx_r == 3'd6) begin
              state_r   <= ST_RUN;
              seqDone_r <= 1'b1;
`ifdef RESET_SEQ_SW_REQ_EN
              if (swPending_r) begin
                swAck_r     <= 1'b1;
                swPending_r <= 1'b0;
              end
`endif
            end
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        ST_RUN: begin
`ifdef RESET_SEQ_SW_REQ_EN
          // A new request is honoured only once the previous handshake has fully closed
          if (sw_reset_req && !swAck_r) begin
            state_r     <= ST_HOLD;
            cnt_r       <= '0;
            idx_r       <= 3'd0;
            memberRst_r <= 7'h7F;
            seqDone_r   <= 1'b0;
            swPending_r <= 1'b1;
          end else begin
            state_r <= ST_RUN;
          end
`else
          state_r <= ST_RUN;
`endif
        end
        default: begin
          state_r     <= ST_HOLD;
          cnt_r       <= '0;
          idx_r       <= 3'd0;
          memberRst_r <= 7'h7F;
          seqDone_r   <= 1'b0;
        end
      endcase
    end
  end

  assign seq_done  = seqDone_r;
  assign seq_state = state_r;
`ifdef RESET_SEQ_SW_REQ_EN
  assign sw_reset_ack = swAck_r;
`endif

  assign auto_out_member_allClocks_implicit_clock_clock   = clock;
  assign auto_out_member_allClocks_subsystem_sbus_0_clock = clock;
  assign auto_out_member_allClocks_subsystem_sbus_1_clock = clock;
  assign auto_out_member_allClocks_subsystem_mbus_clock   = clock;
  assign auto_out_member_allClocks_subsystem_fbus_clock   = clock;
  assign auto_out_member_allClocks_subsystem_cbus_clock   = clock;
  assign auto_out_member_allClocks_subsystem_pbus_clock   = clock;

  assign auto_out_member_allClocks_implicit_clock_reset   = memberRst_r[0];
  assign auto_out_member_allClocks_subsystem_sbus_0_reset = memberRst_r[1];
  assign auto_out_member_allClocks_subsystem_sbus_1_reset = memberRst_r[2];
  assign auto_out_member_allClocks_subsystem_mbus_reset   = memberRst_r[3];
  assign auto_out_member_allClocks_subsystem_fbus_reset   = memberRst_r[4];
  assign auto_out_member_allClocks_subsystem_cbus_reset   = memberRst_r[5];
  assign auto_out_member_allClocks_subsystem_pbus_reset   = memberRst_r[6];

endmodule

// File: tb/tb_clock_group_reset_sequencer.sv
// Scoreboard bench for clock_group_reset_sequencer: a default instance and a minimum-timing instance,
// checked against release-edge arithmetic. Software handshake stimulus follows RESET_SEQ_SW_REQ_EN.
module tb_clock_group_reset_sequencer;
  localparam int H0 = 16, S0 = 4, H1 = 1, S1 = 1;
  localparam int NEVER = 32'h7fffffff;

  typedef struct {
    int inst;
    int member;
    int edgeN;
  } ev_t;

  logic clk = 1'b0;
  logic rst0 = 1'b0;
  logic rst1 = 1'b0;
  wire [6:0] rv0, rv1, cv0, cv1;
  wire done0, done1;
  wire [1:0] st0, st1;
`ifdef RESET_SEQ_SW_REQ_EN
  logic swReq = 1'b0;
  wire ack0, ack1;
`endif

  int cyc = 0;
  int rel [2][7];
  int resetFrom [2];
  bit inRst [2];
  bit swSeq;
  int ackFall;
  int nVec, nErr;
  ev_t evQ [$];
  logic [6:0] prevRv [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  clock_group_reset_sequencer #(.HOLD_CYCLES(H0), .STAGGER_CYCLES(S0)) dut0 (
    .clock(clk), .reset(rst0),
`ifdef RESET_SEQ_SW_REQ_EN
    .sw_reset_req(swReq), .sw_reset_ack(ack0),
`endif
    .seq_done(done0), .seq_state(st0),
    .auto_out_member_allClocks_implicit_clock_clock(cv0[0]),
    .auto_out_member_allClocks_implicit_clock_reset(rv0[0]),
    .auto_out_member_allClocks_subsystem_sbus_0_clock(cv0[1]),
    .auto_out_member_allClocks_subsystem_sbus_0_reset(rv0[1]),
    .auto_out_member_allClocks_subsystem_sbus_1_clock(cv0[2]),
    .auto_out_member_allClocks_subsystem_sbus_1_reset(rv0[2]),
    .auto_out_member_allClocks_subsystem_mbus_clock(cv0[3]),
    .auto_out_member_allClocks_subsystem_mbus_reset(rv0[3]),
    .auto_out_member_allClocks_subsystem_fbus_clock(cv0[4]),
    .auto_out_member_allClocks_subsystem_fbus_reset(rv0[4]),
    .auto_out_member_allClocks_subsystem_cbus_clock(cv0[5]),
    .auto_out_member_allClocks_subsystem_cbus_reset(rv0[5]),
    .auto_out_member_allClocks_subsystem_pbus_clock(cv0[6]),
    .auto_out_member_allClocks_subsystem_pbus_reset(rv0[6])
  );

  clock_group_reset_sequencer #(.HOLD_CYCLES(H1), .STAGGER_CYCLES(S1)) dut1 (
    .clock(clk), .reset(rst1),
`ifdef RESET_SEQ_SW_REQ_EN
    .sw_reset_req(1'b0), .sw_reset_ack(ack1),
`endif
    .seq_done(done1), .seq_state(st1),
    .auto_out_member_allClocks_implicit_clock_clock(cv1[0]),
    .auto_out_member_allClocks_implicit_clock_reset(rv1[0]),
    .auto_out_member_allClocks_subsystem_sbus_0_clock(cv1[1]),
    .auto_out_member_allClocks_subsystem_sbus_0_reset(rv1[1]),
    .auto_out_member_allClocks_subsystem_sbus_1_clock(cv1[2]),
    .auto_out_member_allClocks_subsystem_sbus_1_reset(rv1[2]),
    .auto_out_member_allClocks_subsystem_mbus_clock(cv1[3]),
    .auto_out_member_allClocks_subsystem_mbus_reset(rv1[3]),
    .auto_out_member_allClocks_subsystem_fbus_clock(cv1[4]),
    .auto_out_member_allClocks_subsystem_fbus_reset(rv1[4]),
    .auto_out_member_allClocks_subsystem_cbus_clock(cv1[5]),
    .auto_out_member_allClocks_subsystem_cbus_reset(rv1[5]),
    .auto_out_member_allClocks_subsystem_pbus_clock(cv1[6]),
    .auto_out_member_allClocks_subsystem_pbus_reset(rv1[6])
  );

  task automatic chk(input string name, input int act, input int exp);
    nVec = nVec + 1;
    if (act != exp) begin
      nErr = nErr + 1;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int hOf(input int i);
    return (i == 0) ? H0 : H1;
  endfunction

  function automatic int sOf(input int i);
    return (i == 0) ? S0 : S1;
  endfunction

  // Member k of a sequence whose reference edge is 'base' releases at base + HOLD + k*STAGGER
  function automatic void startSeq(input int i, input int base, input int from);
    for (int k = 0; k < 7; k++) begin
      rel[i][k] = base + hOf(i) + k * sOf(i);
      evQ.push_back('{i, k, rel[i][k]});
    end
    resetFrom[i] = from;
    inRst[i] = 1'b0;
  endfunction

  function automatic void purge(input int i);
    for (int j = evQ.size() - 1; j >= 0; j--)
      if (evQ[j].inst == i) evQ.delete(j);
  endfunction

  function automatic int getRv(input int i);
    return (i == 0) ? int'(rv0) : int'(rv1);
  endfunction

  function automatic int expState(input int i);
    if (inRst[i]) return 0;
    if (cyc < resetFrom[i]) return 2;
    if (cyc < rel[i][0]) return 0;
    if (cyc < rel[i][6]) return 1;
    return 2;
  endfunction

  function automatic int expRv(input int i);
    int v;
    v = 0;
    if (inRst[i]) v = 7'h7F;
    else if (cyc >= resetFrom[i])
      for (int k = 0; k < 7; k++) if (cyc < rel[i][k]) v = v | (1 << k);
    return v;
  endfunction

  // Monitor: per-cycle state checks, plus popping the scoreboard whenever a member reset falls
  initial begin : monitor
    int cur;
    int idx;
    forever begin
      @(negedge clk);
      chk("clk_low", int'({cv1, cv0}), 0);
      for (int i = 0; i < 2; i++) begin
        cur = getRv(i);
        chk(i == 0 ? "rst_vec0" : "rst_vec1", cur, expRv(i));
        chk(i == 0 ? "state0" : "state1", int'(i == 0 ? st0 : st1), expState(i));
        chk(i == 0 ? "done0" : "done1", int'(i == 0 ? done0 : done1), int'(expState(i) == 2));
        for (int k = 0; k < 7; k++) begin
          if (prevRv[i][k] && !cur[k]) begin
            idx = -1;
            for (int j = 0; j < evQ.size(); j++) if (idx < 0 && evQ[j].inst == i) idx = j;
            if (idx < 0) begin
              chk("unexpected_fall", k, -1);
            end else begin
              chk("fall_member", k, evQ[idx].member);
              chk("fall_edge", cyc, evQ[idx].edgeN);
              evQ.delete(idx);
            end
          end
        end
        prevRv[i] = cur[6:0];
      end
`ifdef RESET_SEQ_SW_REQ_EN
      chk("sw_ack", int'(ack0), int'(swSeq && !inRst[0] && cyc >= rel[0][6] && cyc < ackFall));
`endif
    end
  end

  initial begin : clkHighMon
    forever begin
      @(posedge clk);
      #1;
      chk("clk_high", int'({cv1, cv0}), 14'h3FFF);
    end
  end

  task automatic relRst(input int i);
    if (i == 0) rst0 = 1'b1;
    else rst1 = 1'b1;
    startSeq(i, cyc + 2, 0);
  endtask

  // Asynchronous assertion between edges; outputs must react before the next edge
  task automatic assertRst(input int i);
    #2;
    if (i == 0) begin
      rst0 = 1'b0;
      swSeq = 1'b0;
    end else begin
      rst1 = 1'b0;
    end
    inRst[i] = 1'b1;
    purge(i);
    #1;
    chk("async_rst_vec", getRv(i), 7'h7F);
    chk("async_done", int'(i == 0 ? done0 : done1), 0);
    chk("async_state", int'(i == 0 ? st0 : st1), 0);
  endtask

  initial begin : stim
    int at;
    nVec = 0;
    nErr = 0;
    prevRv[0] = 7'h7F;
    prevRv[1] = 7'h7F;
    inRst[0] = 1'b1;
    inRst[1] = 1'b1;
    resetFrom[0] = 0;
    resetFrom[1] = 0;
    swSeq = 1'b0;
    ackFall = NEVER;
    for (int i = 0; i < 2; i++) for (int k = 0; k < 7; k++) rel[i][k] = 0;

    repeat (3) @(negedge clk);
    relRst(1);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    relRst(0);
`ifdef RESET_SEQ_SW_REQ_EN
    repeat (8) @(negedge clk);
    swReq = 1'b1;
    repeat (12) @(negedge clk);
    swReq = 1'b0;
`endif
    repeat (50) @(negedge clk);

    // Minimum-timing instance: reset at a random point mid-sequence
    assertRst(1);
    repeat (3) @(negedge clk);
    relRst(1);
    repeat ($urandom_range(3, 7)) @(negedge clk);
    assertRst(1);
    repeat (2) @(negedge clk);
    relRst(1);

    // Default instance: reset after member 3, then at random points
    for (int it = 0; it < 4; it++) begin
      at = (it == 0) ? 30 : $urandom_range(1, 45);
      @(negedge clk);
      assertRst(0);
      repeat (2) @(negedge clk);
      relRst(0);
      repeat (at) @(negedge clk);
      assertRst(0);
      repeat (5) @(negedge clk);
      relRst(0);
      repeat (H0 + 2 + 6 * S0 + 4) @(negedge clk);
    end

`ifdef RESET_SEQ_SW_REQ_EN
    // Request held past ack: one sequence only, ack drops one edge after req
    @(negedge clk);
    swReq = 1'b1;
    startSeq(0, cyc + 1, cyc + 1);
    swSeq = 1'b1;
    ackFall = NEVER;
    repeat (H0 + 6 * S0 + 16) @(negedge clk);
    swReq = 1'b0;
    ackFall = cyc + 1;
    repeat (4) @(negedge clk);

    // Request dropped early: ack pulses for one cycle at sequence end
    swReq = 1'b1;
    startSeq(0, cyc + 1, cyc + 1);
    ackFall = NEVER;
    @(negedge clk);
    swReq = 1'b0;
    ackFall = rel[0][6] + 1;
    repeat (H0 + 6 * S0 + 4) @(negedge clk);

    // Reset and request together: reset wins
    swReq = 1'b1;
    assertRst(0);
    repeat (2) @(negedge clk);
    swReq = 1'b0;
    relRst(0);
    repeat (H0 + 2 + 6 * S0 + 4) @(negedge clk);
`endif

    chk("pending_releases", evQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
